operand_fetch: RTL

- Decode-to-execute pipeline stage sitting directly upstream of register_file's read ports.
- Drives r1_addr/r2_addr from the incoming instruction and captures r1_data/r2_data into a one-entry output register with a valid/ready handshake.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW hazards.
- Snoops the register_file write port and bypasses same-cycle write data.

---
 rtl/operand_fetch.sv | 114 +++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: drives register_file reads, tracks RAW hazards, registers operands.
// Define OPERAND_FETCH_BYPASS_EN to forward same-cycle writeback data and relieve its hazard.
module operand_fetch #(
    parameter int unsigned           WIDTH         = 32,
    parameter int unsigned           ADDR_SPACE    = 5,
    parameter int unsigned           REG_AMOUNT    = 32,
    parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_SPACE-1:0] in_rs1,
    input  logic [ADDR_SPACE-1:0] in_rs2,
    input  logic [ADDR_SPACE-1:0] in_rd,
    input  logic                  in_wb_en,
    output logic [ADDR_SPACE-1:0] r1_addr,
    output logic [ADDR_SPACE-1:0] r2_addr,
    input  logic [WIDTH-1:0]      r1_data,
    input  logic [WIDTH-1:0]      r2_data,
    input  logic                  wb_en,
    input  logic [ADDR_SPACE-1:0] wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_op1,
    output logic [WIDTH-1:0]      out_op2,
    output logic [ADDR_SPACE-1:0] out_rd,
    output logic                  out_wb_en
);

    logic [REG_AMOUNT-1:0] pending_q, pending_d;
    logic                  out_valid_q;
    logic [WIDTH-1:0]      out_op1_q, out_op2_q;
    logic [ADDR_SPACE-1:0] out_rd_q;
    logic                  out_wb_en_q;
    logic                  wb_hit1, wb_hit2;
    logic                  haz1, haz2;
    logic                  accept;
    logic [WIDTH-1:0]      op1, op2;

    assign r1_addr = in_rs1;
    assign r2_addr = in_rs2;

`ifdef OPERAND_FETCH_BYPASS_EN
    assign wb_hit1 = wb_en & (wb_addr == in_rs1) & (in_rs1 != ZERO_REGISTER);
    assign wb_hit2 = wb_en & (wb_addr == in_rs2) & (in_rs2 != ZERO_REGISTER);
`else
    // Without forwarding a consumer waits for the register_file write to land.
    assign wb_hit1 = 1'b0;
    assign wb_hit2 = 1'b0;
`endif

    assign haz1 = pending_q[in_rs1] & ~wb_hit1 & (in_rs1 != ZERO_REGISTER);
    assign haz2 = pending_q[in_rs2] & ~wb_hit2 & (in_rs2 != ZERO_REGISTER);

    assign in_ready = (~out_valid_q | out_ready) & ~haz1 & ~haz2;
    assign accept   = in_valid & in_ready;

    always_comb begin
        op1 = r1_data;
        op2 = r2_data;
        if (in_rs1 == ZERO_REGISTER) begin
            op1 = '0;
        end else if (wb_hit1) begin
            op1 = wb_data;
        end
        if (in_rs2 == ZERO_REGISTER) begin
            op2 = '0;
        end else if (wb_hit2) begin
            op2 = wb_data;
        end
    end

    // Set is applied after clear so a new producer of the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (wb_en && (wb_addr != ZERO_REGISTER)) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (accept && in_wb_en && (in_rd != ZERO_REGISTER)) begin
            pending_d[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_op1_q   <= '0;
            out_op2_q   <= '0;
            out_rd_q    <= '0;
            out_wb_en_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_op1_q   <= op1;
                out_op2_q   <= op2;
                out_rd_q    <= in_rd;
                out_wb_en_q <= in_wb_en;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_op1   = out_op1_q;
    assign out_op2   = out_op2_q;
    assign out_rd    = out_rd_q;
    assign out_wb_en = out_wb_en_q;

endmodule
